ifm_bank_receiver: RTL and testbench
====================================

# ifm_bank_receiver

Receive side of the inter-layer feature-map hand-off. Accepts the word writes, bank select and start pulse that a convolution layer's control unit emits toward the next layer. Stores them in two ping-pong banks of per-channel IFM memory and serves the stored map to the local layer's control unit. Returns the end pulse that lets the upstream producer reuse a bank. It sits at the input of every layer after ConvA1, between the upstream layer's write port and the local CU/DP read port.

## Interface
Parameters:
- DATA_WIDTH, 32, word width
- IFM_SIZE, 28, feature-map side length
- NUMBER_OF_IFM, 6, channels stored per bank (one memory per channel)
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), word address width

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- data_in_from_previous  in  DATA_WIDTH  write data
- ifm_address_write_previous  in  ADDRESS_SIZE_IFM  write address
- ifm_enable_write_previous  in  NUMBER_OF_IFM  per-channel write enable
- ifm_sel_previous  in  1  bank targeted by writes and by start
- start_from_previous  in  1  one-cycle pulse: bank ifm_sel_previous complete
- end_to_previous  out  1  one-cycle pulse: a bank was released
- ifm_enable_read_current  in  1  read strobe from local CU
- ifm_address_read_current  in  ADDRESS_SIZE_IFM  read address
- data_out_current  out  DATA_WIDTH*NUMBER_OF_IFM  all channels, channel 0 in LSBs
- start_to_current  out  1  one-cycle pulse: a bank is ready to read
- ifm_sel_current  out  1  bank currently served to reads
- end_from_current  in  1  one-cycle pulse: local layer finished with active bank
- protocol_error  out  1  sticky upstream protocol violation

## Operation
- Each bank has its own state machine: EMPTY -> FILLED on start_from_previous with ifm_sel_previous = bank.
- FILLED -> ACTIVE when no bank is ACTIVE and the bank equals rd_ptr.
- ACTIVE -> EMPTY on end_from_current.
- rd_ptr (reset 0) toggles on every ACTIVE->EMPTY transition; wr_exp (reset 0) toggles on every accepted start_from_previous. Banks are consumed strictly in fill order.
- Writes: each channel c with ifm_enable_write_previous[c]=1 writes data_in_from_previous at the given address into bank ifm_sel_previous.
- Reads: when ifm_enable_read_current=1, all channels of bank ifm_sel_current are read at the given address. When it is 0, data_out_current holds its last value.
- ifm_sel_current equals rd_ptr.
- Out-of-range addresses (>= IFM_SIZE*IFM_SIZE) on a write are dropped. On a read they return 0.
- Memory contents are not cleared by reset.

## Timing
- Reset values: end_to_previous=0, start_to_current=0, ifm_sel_current=0, data_out_current=0, protocol_error=0. Both banks EMPTY.
- No end_to_previous pulse follows reset. Upstream may write bank 0, then bank 1, immediately.
- Read latency is 1: data is registered on the cycle after the strobe.
- Write-to-read latency is 1 (write-first is not required across banks).
- The FILLED->ACTIVE transition occurs on the edge after the qualifying condition. start_to_current pulses in the same cycle the bank becomes ACTIVE, so minimum start_from_previous -> start_to_current is 1 cycle.
- end_from_current at edge N: bank EMPTY and end_to_previous=1 during cycle N+1, for exactly one cycle. If the other bank is FILLED, it becomes ACTIVE and start_to_current pulses at edge N+1.
- start_from_previous for bank B and end_from_current for bank !B in the same cycle: both apply. B becomes ACTIVE one edge later.
- end_from_current with no ACTIVE bank is ignored.
- Reset asserted mid-map discards all bank states and pending pulses.

## Configuration
- IFM_RX_ERR_EN defined: protocol checking is enabled. Each of the following sets protocol_error until reset, and the offending event is ignored:
  - a write to an ACTIVE or FILLED bank (write dropped)
  - start_from_previous for a non-EMPTY bank
  - start_from_previous with ifm_sel_previous != wr_exp
- IFM_RX_ERR_EN undefined: no checking; writes always land; start for a non-EMPTY bank is ignored; protocol_error is tied 0.

## Structure
- Shared package holds the bank-state enum (EMPTY, FILLED, ACTIVE) and the $clog2-derived address width function.
- One sub-module, ifm_bank_ram: a single-channel, dual-port (1 write, 1 registered read) memory of IFM_SIZE*IFM_SIZE words. It is instantiated 2*NUMBER_OF_IFM times. The top holds the two state machines, the pointers and the output mux.

## Test plan
- After reset, write 784 words (value = address) to bank 0 on all channels, then pulse start -> start_to_current at the next cycle with ifm_sel_current=0; reading address 17 returns 17 in every channel one cycle later.
- Fill bank 0 and bank 1 back-to-back, then pulse end_from_current -> end_to_previous=1 for one cycle, then start_to_current with ifm_sel_current=1 on the following edge.
- Pulse start_from_previous(bank 1) in the same cycle as end_from_current(bank 0) -> bank 1 ACTIVE one edge later; a single end_to_previous pulse.
- With IFM_RX_ERR_EN, write to the ACTIVE bank 0 at address 5 with value 0xDEAD -> protocol_error=1 and address 5 is unchanged; without the macro, the word is overwritten and protocol_error stays 0.
- Assert reset while bank 0 is ACTIVE -> all outputs 0, rd_ptr=0, and a new fill of bank 0 is accepted without error.
- Read address 784 -> data_out_current=0 one cycle later.

Source files
------------

// File: rtl/ifm_bank_receiver_pkg.sv
// Shared types for the inter-layer IFM bank receiver: bank state encoding and
// the feature-map address width helper.
package ifm_bank_receiver_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY  = 2'd0,
    BANK_FILLED = 2'd1,
    BANK_ACTIVE = 2'd2
  } bank_state_t;

  function automatic int ifm_addr_width(input int ifm_size);
    return $clog2(ifm_size * ifm_size);
  endfunction

endpackage

// File: rtl/ifm_bank_receiver_if.sv
// Bundle of the upstream write/start/end port and the local read/start/end port
// of the IFM bank receiver. slave = receiver view, master = environment view.
interface ifm_bank_receiver_if
  import ifm_bank_receiver_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 28,
  parameter int NUMBER_OF_IFM    = 6,
  parameter int ADDRESS_SIZE_IFM = ifm_addr_width(IFM_SIZE)
) ();

  // No valid/ready pairs here: start_*/end_* are single-cycle event pulses sampled
  // on the rising edge, writes/reads are qualified by their enable for that one
  // edge only, and the receiver never back-pressures the upstream producer.
  logic [DATA_WIDTH-1:0]               data_in_from_previous;
  logic [ADDRESS_SIZE_IFM-1:0]         ifm_address_write_previous;
  logic [NUMBER_OF_IFM-1:0]            ifm_enable_write_previous;
  logic                                ifm_sel_previous;
  logic                                start_from_previous;
  logic                                end_to_previous;
  logic                                ifm_enable_read_current;
  logic [ADDRESS_SIZE_IFM-1:0]         ifm_address_read_current;
  logic [DATA_WIDTH*NUMBER_OF_IFM-1:0] data_out_current;
  logic                                start_to_current;
  logic                                ifm_sel_current;
  logic                                end_from_current;
  logic                                protocol_error;

  modport slave (
    input  data_in_from_previous, ifm_address_write_previous, ifm_enable_write_previous,
    input  ifm_sel_previous, start_from_previous,
    input  ifm_enable_read_current, ifm_address_read_current, end_from_current,
    output end_to_previous, data_out_current, start_to_current, ifm_sel_current,
    output protocol_error
  );

  modport master (
    output data_in_from_previous, ifm_address_write_previous, ifm_enable_write_previous,
    output ifm_sel_previous, start_from_previous,
    output ifm_enable_read_current, ifm_address_read_current, end_from_current,
    input  end_to_previous, data_out_current, start_to_current, ifm_sel_current,
    input  protocol_error
  );

endinterface

// File: rtl/ifm_bank_receiver_ram.sv
// ifm_bank_ram: one channel of one bank. One write port, one registered read port;
// out-of-range writes are dropped and out-of-range reads return zero.
module ifm_bank_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 784,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;

  // Extra top bit keeps the compare exact when DEPTH is a power of two.
  assign w_wr_in_range = {1'b0, i_wr_addr} < (ADDR_WIDTH+1)'(DEPTH);
  assign w_rd_in_range = {1'b0, i_rd_addr} < (ADDR_WIDTH+1)'(DEPTH);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_we && w_wr_in_range) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= w_rd_in_range ? r_mem[i_rd_addr] : '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ifm_bank_receiver.sv
// Ping-pong IFM receiver: two banks of per-channel memory, one state machine per bank.
// Build with IFM_RX_ERR_EN defined to enable upstream protocol checking.
module ifm_bank_receiver
  import ifm_bank_receiver_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 28,
  parameter int NUMBER_OF_IFM    = 6,
  parameter int ADDRESS_SIZE_IFM = ifm_addr_width(IFM_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  ifm_bank_receiver_if.slave    bus,
  output logic [3:0]            o_dbg_bank_state,
  output logic                  o_dbg_wr_exp
);

  localparam int DEPTH = IFM_SIZE * IFM_SIZE;

  bank_state_t r_state [2];
  bank_state_t w_state_nxt [2];
  logic r_rd_ptr, w_rd_ptr_nxt;
  logic r_wr_exp, w_wr_exp_nxt;
  logic r_err, w_err_nxt;
  logic r_end, w_end_nxt;
  logic r_start, w_start_nxt;
  logic r_rd_bank;

  logic w_any_active, w_end_ok, w_start_ok, w_promote, w_err_evt;
  logic w_wr_bank_empty, w_wr_allowed;

  logic [NUMBER_OF_IFM-1:0] w_we [2];
  logic [1:0]               w_rd_en;
  logic [DATA_WIDTH-1:0]    w_rd_data [2][NUMBER_OF_IFM];

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) r_state[b] <= BANK_EMPTY;
      r_rd_ptr  <= 1'b0;
      r_wr_exp  <= 1'b0;
      r_err     <= 1'b0;
      r_end     <= 1'b0;
      r_start   <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) r_state[b] <= w_state_nxt[b];
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_exp <= w_wr_exp_nxt;
      r_err    <= w_err_nxt;
      r_end    <= w_end_nxt;
      r_start  <= w_start_nxt;
      if (bus.ifm_enable_read_current) r_rd_bank <= r_rd_ptr;
    end
  end

  // ---------------- next-state logic ----------------
  assign w_wr_bank_empty = (r_state[bus.ifm_sel_previous] == BANK_EMPTY);

`ifdef IFM_RX_ERR_EN
  assign w_wr_allowed = w_wr_bank_empty;
  assign w_err_evt    = (|bus.ifm_enable_write_previous && !w_wr_bank_empty) ||
                        (bus.start_from_previous &&
                         (!w_wr_bank_empty || (bus.ifm_sel_previous != r_wr_exp)));
`else
  assign w_wr_allowed = 1'b1;
  assign w_err_evt    = 1'b0;
`endif

  always_comb begin
    for (int b = 0; b < 2; b++) w_state_nxt[b] = r_state[b];
    w_any_active = (r_state[0] == BANK_ACTIVE) || (r_state[1] == BANK_ACTIVE);
    w_end_ok     = bus.end_from_current && w_any_active;
    w_start_ok   = bus.start_from_previous && w_wr_bank_empty;
`ifdef IFM_RX_ERR_EN
    w_start_ok   = w_start_ok && (bus.ifm_sel_previous == r_wr_exp);
`endif
    // Only the bank at rd_ptr may go live, which enforces fill-order consumption.
    w_promote    = !w_any_active && (r_state[r_rd_ptr] == BANK_FILLED);

    for (int b = 0; b < 2; b++) begin
      if (w_end_ok && (r_state[b] == BANK_ACTIVE)) begin
        w_state_nxt[b] = BANK_EMPTY;
      end else if (w_promote && (r_rd_ptr == 1'(b))) begin
        w_state_nxt[b] = BANK_ACTIVE;
      end else if (w_start_ok && (bus.ifm_sel_previous == 1'(b))) begin
        w_state_nxt[b] = BANK_FILLED;
      end
    end

    w_rd_ptr_nxt = r_rd_ptr ^ w_end_ok;
    w_wr_exp_nxt = r_wr_exp ^ w_start_ok;
    w_err_nxt    = r_err | w_err_evt;
    w_end_nxt    = w_end_ok;
    w_start_nxt  = w_promote;
  end

  // ---------------- output logic ----------------
  always_comb begin
    bus.end_to_previous  = r_end;
    bus.start_to_current = r_start;
    bus.ifm_sel_current  = r_rd_ptr;
    bus.protocol_error   = r_err;
    o_dbg_bank_state     = {r_state[1], r_state[0]};
    o_dbg_wr_exp         = r_wr_exp;
    bus.data_out_current = '0;
    for (int c = 0; c < NUMBER_OF_IFM; c++) begin
      bus.data_out_current[c*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[r_rd_bank][c];
    end
  end

  // ---------------- memories ----------------
  // Only the served bank is strobed, so the other bank's read registers hold
  // and the output stays stable while the strobe is low.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_rd_en[b] = bus.ifm_enable_read_current && (r_rd_ptr == 1'(b));
    for (genvar c = 0; c < NUMBER_OF_IFM; c++) begin : g_ch
      assign w_we[b][c] = bus.ifm_enable_write_previous[c] && w_wr_allowed &&
                          (bus.ifm_sel_previous == 1'(b));
      ifm_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDRESS_SIZE_IFM)
      ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_we[b][c]),
        .i_wr_addr (bus.ifm_address_write_previous),
        .i_wr_data (bus.data_in_from_previous),
        .i_rd_en   (w_rd_en[b]),
        .i_rd_addr (bus.ifm_address_read_current),
        .o_rd_data (w_rd_data[b][c])
      );
    end
  end

endmodule

// File: tb/tb_ifm_bank_receiver.sv
// Directed self-checking bench for ifm_bank_receiver; expectations adapt to IFM_RX_ERR_EN.
module tb_ifm_bank_receiver;
  import ifm_bank_receiver_pkg::*;

  localparam int DW    = 32;
  localparam int SZ    = 28;
  localparam int N     = 6;
  localparam int AW    = ifm_addr_width(SZ);
  localparam int DEPTH = SZ * SZ;
  localparam int OW    = DW * N;
`ifdef IFM_RX_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifm_bank_receiver_if #(.DATA_WIDTH(DW), .IFM_SIZE(SZ), .NUMBER_OF_IFM(N),
                         .ADDRESS_SIZE_IFM(AW)) bus ();
  logic [3:0] dbg_state;
  logic       dbg_wr_exp;

  ifm_bank_receiver #(.DATA_WIDTH(DW), .IFM_SIZE(SZ), .NUMBER_OF_IFM(N),
                      .ADDRESS_SIZE_IFM(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .o_dbg_bank_state (dbg_state),
    .o_dbg_wr_exp     (dbg_wr_exp)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [OW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.data_in_from_previous      = '0;
    bus.ifm_address_write_previous = '0;
    bus.ifm_enable_write_previous  = '0;
    bus.ifm_sel_previous           = 1'b0;
    bus.start_from_previous        = 1'b0;
    bus.ifm_enable_read_current    = 1'b0;
    bus.ifm_address_read_current   = '0;
    bus.end_from_current           = 1'b0;
  endtask

  task automatic write_word(input logic bank, input int addr, input logic [DW-1:0] data);
    bus.ifm_sel_previous           = bank;
    bus.ifm_address_write_previous = AW'(addr);
    bus.data_in_from_previous      = data;
    bus.ifm_enable_write_previous  = '1;
    step();
    bus.ifm_enable_write_previous  = '0;
  endtask

  task automatic pulse_start(input logic bank);
    bus.ifm_sel_previous    = bank;
    bus.start_from_previous = 1'b1;
    step();
    bus.start_from_previous = 1'b0;
  endtask

  task automatic pulse_end();
    bus.end_from_current = 1'b1;
    step();
    bus.end_from_current = 1'b0;
  endtask

  task automatic read_check(input string tag, input int addr, input logic [DW-1:0] word);
    exp_q.push_back({N{word}});
    bus.ifm_address_read_current = AW'(addr);
    bus.ifm_enable_read_current  = 1'b1;
    step();
    bus.ifm_enable_read_current  = 1'b0;
    check(tag, bus.data_out_current, exp_q.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    check("rst_end",    bus.end_to_previous, 0);
    check("rst_start",  bus.start_to_current, 0);
    check("rst_sel",    bus.ifm_sel_current, 0);
    check("rst_data",   bus.data_out_current, 0);
    check("rst_err",    bus.protocol_error, 0);
    check("rst_states", dbg_state, 4'b0000);

    // Fill bank 0 with value = address on all channels.
    for (int a = 0; a < DEPTH; a++) write_word(1'b0, a, DW'(a));
    pulse_start(1'b0);
    check("fill0_start_lat", bus.start_to_current, 0);
    check("fill0_filled",    dbg_state, 4'b0001);
    check("fill0_wr_exp",    dbg_wr_exp, 1);
    step();
    check("fill0_start", bus.start_to_current, 1);
    check("fill0_sel",   bus.ifm_sel_current, 0);
    check("fill0_active", dbg_state, 4'b0010);
    step();
    check("fill0_start_1cyc", bus.start_to_current, 0);
    read_check("rd_addr17", 17, 32'd17);
    step();
    check("rd_hold", bus.data_out_current, {N{32'd17}});
    read_check("rd_last", DEPTH - 1, DW'(DEPTH - 1));

    // Write into the live bank.
    write_word(1'b0, 5, 32'hDEAD);
    check("wr_active_err", bus.protocol_error, ERR);
    read_check("wr_active_rd5", 5, ERR ? 32'd5 : 32'hDEAD);
    read_check("rd_oor", DEPTH, 32'd0);

    // Fill bank 1 while bank 0 is still being served.
    for (int a = 0; a < 4; a++) write_word(1'b1, a, DW'(100 + a));
    pulse_start(1'b1);
    check("fill1_states", dbg_state, 4'b0110);
    check("fill1_wr_exp", dbg_wr_exp, 0);
    step();
    check("fill1_no_start", bus.start_to_current, 0);
    pulse_end();
    check("end0_pulse",  bus.end_to_previous, 1);
    check("end0_nostart", bus.start_to_current, 0);
    check("end0_sel",    bus.ifm_sel_current, 1);
    check("end0_states", dbg_state, 4'b0100);
    step();
    check("end0_pulse_1cyc", bus.end_to_previous, 0);
    check("swap1_start",     bus.start_to_current, 1);
    check("swap1_states",    dbg_state, 4'b1000);
    read_check("rd_b1_addr2", 2, 32'd102);

    // Refill bank 0 while bank 1 is released in the same cycle as the start.
    write_word(1'b0, 0, 32'h55);
    bus.ifm_sel_previous    = 1'b0;
    bus.start_from_previous = 1'b1;
    bus.end_from_current    = 1'b1;
    step();
    bus.start_from_previous = 1'b0;
    bus.end_from_current    = 1'b0;
    check("same_end_pulse", bus.end_to_previous, 1);
    check("same_states",    dbg_state, 4'b0001);
    check("same_sel",       bus.ifm_sel_current, 0);
    check("same_no_start",  bus.start_to_current, 0);
    step();
    check("same_single_end", bus.end_to_previous, 0);
    check("same_start",      bus.start_to_current, 1);
    check("same_active",     dbg_state, 4'b0010);
    read_check("rd_b0_addr0", 0, 32'h55);

    // Reset while bank 0 is ACTIVE.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_data",   bus.data_out_current, 0);
    check("mid_rst_sel",    bus.ifm_sel_current, 0);
    check("mid_rst_start",  bus.start_to_current, 0);
    check("mid_rst_end",    bus.end_to_previous, 0);
    check("mid_rst_err",    bus.protocol_error, 0);
    check("mid_rst_states", dbg_state, 4'b0000);
    check("mid_rst_wr_exp", dbg_wr_exp, 0);
    write_word(1'b0, 9, 32'h99);
    pulse_start(1'b0);
    step();
    check("refill_start", bus.start_to_current, 1);
    check("refill_err",   bus.protocol_error, 0);
    read_check("refill_rd9", 9, 32'h99);
    read_check("mem_kept_rd3", 3, 32'd3);

    // Release, then a stray end with no live bank.
    pulse_end();
    check("end_b0_pulse",  bus.end_to_previous, 1);
    check("end_b0_states", dbg_state, 4'b0000);
    pulse_end();
    check("stray_end_ignored", bus.end_to_previous, 0);
    check("stray_end_sel",     bus.ifm_sel_current, 1);

    // Start for bank 0 when bank 1 is the expected next fill.
    pulse_start(1'b0);
    check("order_err",    bus.protocol_error, ERR);
    check("order_states", dbg_state, ERR ? 4'b0000 : 4'b0001);
    step();
    check("order_no_start", bus.start_to_current, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
